// File: rtl/vrf_rd_port_pkg.sv
// rtl/vrf_rd_port_pkg.sv - shared vector register file configuration types
package vrf_rd_port_pkg;

    localparam int NUM_VREGS = 32;
    localparam int ADDR_W    = 6;   // one bit wider than needed so out-of-range indices are representable
    localparam int DATA_W    = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/rd_resp_fifo.sv
// rtl/rd_resp_fifo.sv - in-order response buffer for the register file read port
//
// Ports:
//   clk_i, arst_ni      clock, asynchronous active-low reset
//   push_i, push_data_i enqueue one entry (taken when not full, or when popping)
//   pop_i, pop_data_o   dequeue head entry; pop_data_o shows the head
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries
module rd_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Pointer wrap that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (count == CW'(DEPTH));
    assign empty_o    = (count == '0);
    assign count_o    = count;
    assign pop_data_o = mem[rptr];
    assign do_pop     = pop_i && !empty_o;
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign do_push    = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data_i;
                wptr      <= ptr_inc(wptr);
            end
            if (do_pop) begin
                rptr <= ptr_inc(rptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vrf_rd_port.sv
// rtl/vrf_rd_port.sv - vector register file with one buffered in-order read port
//
// Ports:
//   clk_i, arst_ni                            clock, asynchronous active-low reset
//   rd_addr_valid_i/rd_addr_i/rd_addr_ready_o read request handshake
//   rd_data_valid_o/rd_data_o/rd_data_ready_i read response handshake
//   wr_en_i/wr_addr_i/wr_data_i               writeback port
module vrf_rd_port
    import vrf_rd_port_pkg::*;
#(
    parameter int NUM_REGS   = NUM_VREGS,
    parameter int RESP_DEPTH = 2
) (
    input  logic  clk_i,
    input  logic  arst_ni,
    input  logic  rd_addr_valid_i,
    input  addr_t rd_addr_i,
    output logic  rd_addr_ready_o,
    output logic  rd_data_valid_o,
    output data_t rd_data_o,
    input  logic  rd_data_ready_i,
    input  logic  wr_en_i,
    input  addr_t wr_addr_i,
    input  data_t wr_data_i
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    data_t         regs [NUM_REGS];
    data_t         rd_value;
    logic          rd_in_range;
    logic          ready_en;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] occ;

    // Holds ready low through reset and rises on the first edge after release.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Storage is read on the accept edge and pushed straight into the buffer,
    // so occupancy is just the buffer count (no separate in-flight stage).
    assign rd_addr_ready_o = ready_en && (occ < CW'(RESP_DEPTH));
    assign rd_data_valid_o = !fifo_empty;
    assign rd_in_range     = (rd_addr_i < ADDR_W'(NUM_REGS));

    // Write-first bypass; out-of-range reads return zero even if a write
    // targets the same (ignored) index.
    always_comb begin
        rd_value = '0;
        if (rd_in_range) begin
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_value = wr_data_i;
            end else begin
                rd_value = regs[rd_addr_i[IW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
                    regs[i] <= wr_data_i;
                end
            end
        end
    end

    rd_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .push_i      (rd_addr_valid_i && ready_en && !fifo_full),
        .push_data_i (rd_value),
        .pop_i       (rd_data_ready_i),
        .pop_data_o  (rd_data_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (occ)
    );

endmodule

// File: tb/tb_vrf_rd_port.sv
// tb/tb_vrf_rd_port.sv - directed self-checking bench for vrf_rd_port
module tb_vrf_rd_port;
    import vrf_rd_port_pkg::*;

    logic  clk;
    logic  arst_n;
    logic  rd_addr_valid;
    addr_t rd_addr;
    logic  rd_addr_ready;
    logic  rd_data_valid;
    data_t rd_data;
    logic  rd_data_ready;
    logic  wr_en;
    addr_t wr_addr;
    data_t wr_data;

    int n_assert = 0;
    int n_fail   = 0;

    vrf_rd_port #(
        .NUM_REGS   (32),
        .RESP_DEPTH (2)
    ) dut (
        .clk_i           (clk),
        .arst_ni         (arst_n),
        .rd_addr_valid_i (rd_addr_valid),
        .rd_addr_i       (rd_addr),
        .rd_addr_ready_o (rd_addr_ready),
        .rd_data_valid_o (rd_data_valid),
        .rd_data_o       (rd_data),
        .rd_data_ready_i (rd_data_ready),
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n        = 1'b0;
        rd_addr_valid = 1'b0;
        rd_addr       = '0;
        rd_data_ready = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;

        #3;
        chk("reset_ready", 32'(rd_addr_ready), 32'd0);
        chk("reset_valid", 32'(rd_data_valid), 32'd0);
        chk("reset_data", rd_data, 32'd0);
        tick();
        tick();
        arst_n = 1'b1;
        tick();
        chk("ready_after_release", 32'(rd_addr_ready), 32'd1);

        // Write r3=A5, then read it back with one-cycle latency.
        rd_data_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'hA5;
        tick();
        wr_en = 1'b0;
        rd_addr_valid = 1'b1; rd_addr = 6'd3;
        tick();
        rd_addr_valid = 1'b0;
        chk("t1_valid", 32'(rd_data_valid), 32'd1);
        chk("t1_data", rd_data, 32'hA5);
        tick();
        chk("t1_popped", 32'(rd_data_valid), 32'd0);

        // Preload r1..r4 = 1..4, then back-to-back reads.
        for (int k = 1; k <= 4; k++) begin
            wr_en = 1'b1; wr_addr = addr_t'(k); wr_data = data_t'(k);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            rd_addr_valid = 1'b1; rd_addr = addr_t'(k);
            chk($sformatf("t2_ready_%0d", k), 32'(rd_addr_ready), 32'd1);
            tick();
            chk($sformatf("t2_valid_%0d", k), 32'(rd_data_valid), 32'd1);
            chk($sformatf("t2_data_%0d", k), rd_data, 32'(k));
        end
        rd_addr_valid = 1'b0;
        tick();
        chk("t2_drained", 32'(rd_data_valid), 32'd0);

        // Backpressure: three requests offered, two accepted.
        rd_data_ready = 1'b0;
        rd_addr_valid = 1'b1; rd_addr = 6'd1;
        tick();
        rd_addr = 6'd2;
        tick();
        chk("t3_ready_low", 32'(rd_addr_ready), 32'd0);
        rd_addr = 6'd3;
        tick();
        chk("t3_ready_still_low", 32'(rd_addr_ready), 32'd0);
        chk("t3_head_stable", rd_data, 32'd1);
        rd_data_ready = 1'b1;
        tick();
        chk("t3_ready_after_pop", 32'(rd_addr_ready), 32'd1);
        chk("t3_second", rd_data, 32'd2);
        tick();
        rd_addr_valid = 1'b0;
        chk("t3_third_valid", 32'(rd_data_valid), 32'd1);
        chk("t3_third", rd_data, 32'd3);
        tick();
        chk("t3_drained", 32'(rd_data_valid), 32'd0);

        // Same-edge read/write bypass and capture at request time.
        rd_data_ready = 1'b0;
        rd_addr_valid = 1'b1; rd_addr = 6'd5;
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'h77;
        tick();
        rd_addr_valid = 1'b0;
        wr_data = 32'h11;
        tick();
        wr_en = 1'b0;
        chk("t4_bypass", rd_data, 32'h77);
        rd_data_ready = 1'b1;
        tick();
        chk("t4_popped", 32'(rd_data_valid), 32'd0);
        rd_addr_valid = 1'b1; rd_addr = 6'd5;
        tick();
        rd_addr_valid = 1'b0;
        chk("t4_r5_new", rd_data, 32'h11);
        tick();

        // Out-of-range index between in-range neighbours; write to it ignored.
        rd_addr_valid = 1'b1; rd_addr = 6'd2;
        tick();
        chk("t5_first", rd_data, 32'd2);
        rd_addr = 6'd32;
        wr_en = 1'b1; wr_addr = 6'd32; wr_data = 32'hFF;
        tick();
        wr_en = 1'b0;
        chk("t5_oob_valid", 32'(rd_data_valid), 32'd1);
        chk("t5_oob_zero", rd_data, 32'd0);
        rd_addr = 6'd4;
        tick();
        rd_addr_valid = 1'b0;
        chk("t5_last", rd_data, 32'd4);
        tick();
        chk("t5_drained", 32'(rd_data_valid), 32'd0);

        // Reset with two responses buffered.
        rd_data_ready = 1'b0;
        rd_addr_valid = 1'b1; rd_addr = 6'd1;
        tick();
        rd_addr = 6'd2;
        tick();
        rd_addr_valid = 1'b0;
        chk("t6_buffered", 32'(rd_data_valid), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(rd_data_valid), 32'd0);
        chk("t6_rst_ready", 32'(rd_addr_ready), 32'd0);
        chk("t6_rst_data", rd_data, 32'd0);
        #1;
        arst_n = 1'b1;
        tick();
        chk("t6_ready_release", 32'(rd_addr_ready), 32'd1);
        rd_data_ready = 1'b1;
        rd_addr_valid = 1'b1; rd_addr = 6'd3;
        tick();
        rd_addr_valid = 1'b0;
        chk("t6_cleared_valid", 32'(rd_data_valid), 32'd1);
        chk("t6_cleared_data", rd_data, 32'd0);
        tick();
        chk("t6_drained", 32'(rd_data_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vrf_rd_port.md
VRF_RD_PORT -- requirements
Module: vrf_rd_port

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of vector registers held (the shared package supplies the default).
REQ-002 SHALL have parameter RESP_DEPTH, default 2, response buffer entries.
REQ-003 SHALL have clk_i, input, 1, the single clock; reset is asynchronous and active-low.
REQ-004 SHALL have arst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have rd_addr_valid_i, input, 1, read request valid from the address sequencer.
REQ-006 SHALL have rd_addr_i, input, addr_t, register index to read.
REQ-007 SHALL have rd_addr_ready_o, output, 1, request accepted when valid and ready are both high.
REQ-008 SHALL have rd_data_valid_o, output, 1, read data valid.
REQ-009 SHALL have rd_data_o, output, data_t, read data.
REQ-010 SHALL have rd_data_ready_i, input, 1, consumer accepts data.
REQ-011 SHALL have wr_en_i, input, 1, writeback enable.
REQ-012 SHALL have wr_addr_i, input, addr_t, writeback index.
REQ-013 SHALL have wr_data_i, input, data_t, writeback data.

Function
REQ-014 SHALL accept a request on a clock edge where rd_addr_valid_i and rd_addr_ready_o are both 1.
REQ-015 SHALL read storage on the accept edge, so the data reaches the response buffer and rd_data_valid_o can rise on the next cycle: 1-cycle minimum latency.
REQ-016 SHALL return responses strictly in request order, exactly one response per accepted request.
REQ-017 SHALL drive rd_addr_ready_o = (occupancy < RESP_DEPTH), with no combinational path from rd_data_ready_i; occupancy = reads in flight + buffered entries.
REQ-018 SHALL sustain one request per cycle when rd_data_ready_i is held 1.
REQ-019 SHALL, when occupancy = RESP_DEPTH, hold ready low until a response is popped (rd_data_valid_o and rd_data_ready_i both high); ready rises the cycle after the pop.
REQ-020 SHALL keep rd_data_o and rd_data_valid_o stable while rd_data_valid_o=1 and rd_data_ready_i=0.
REQ-021 SHALL write wr_data_i to wr_addr_i on each edge where wr_en_i=1; a write does not block reads.
REQ-022 SHALL, when a read and a write to the same index occur on the same edge, return wr_data_i (write-first bypass).
REQ-023 SHALL, for a read index >= NUM_REGS, return all-zero data and still consume one response slot; a write to such an index is ignored.
REQ-024 SHALL capture read data at request time, so later writes do not alter an already-buffered response.
REQ-025 SHALL allow a push and a pop in the same cycle when the buffer is full, leaving occupancy unchanged.

Reset
REQ-026 SHALL, while arst_ni=0, force rd_addr_ready_o=0, rd_data_valid_o=0, rd_data_o=0, occupancy=0 and all storage to 0, asynchronously.
REQ-027 SHALL drop in-flight and buffered responses on reset mid-operation; rd_addr_ready_o=1 on the first edge after release.

Structure
REQ-028 SHALL take addr_t, data_t and NUM_VREGS from the shared config package; no local redefinition.
REQ-029 SHALL implement the response buffer as one sub-module, rd_resp_fifo (parameterised depth and width, with push, pop, full, empty and count signals).
REQ-030 SHALL be 120-400 lines of RTL in total.

Verification
REQ-031 SHALL cover this case: write 0xA5 to r3, then read r3 with ready_i=1 -> rd_data_valid_o=1 one cycle after accept, data 0xA5.
REQ-032 SHALL cover this case: back-to-back reads r1, r2, r3, r4 (preloaded 1..4) with ready_i=1 -> data 1, 2, 3, 4 on 4 consecutive cycles, ready_o never low.
REQ-033 SHALL cover this case: ready_i=0 with 3 requests offered -> 2 accepted, ready_o=0 from the next cycle; release ready_i -> 2 responses in order, then the third is accepted.
REQ-034 SHALL cover this case: read r5 and write r5=0x77 on the same edge -> response 0x77; a subsequent write r5=0x11 before the pop does not change the buffered 0x77.
REQ-035 SHALL cover this case: read index NUM_REGS (32) -> response 0, ordering preserved against neighbouring reads.
REQ-036 SHALL cover this case: assert arst_ni=0 with 2 responses buffered -> rd_data_valid_o=0 immediately; after release, a read of any register returns 0.
